// File: rtl/pattern_pkg.sv
// Shared types and width helpers for the serializer feeding the pattern-detector stage.
package pattern_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } st_e;

    localparam logic IDLE_LEVEL_DEF = 1'b0;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/bit_rate_divider.sv
// Per-bit cycle counter; tick is a lookahead flag meaning "the coming cycle is the last of its bit".
module bit_rate_divider
    import pattern_pkg::*;
#(
    parameter int unsigned BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DW = cnt_w(BIT_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 32'd1);

    logic [DW-1:0] div_cnt_r;
    logic [DW-1:0] div_cnt_next_s;

    // Next count: explicit reload on clear or at the end of a bit period, hold when disabled
    always_comb begin
        div_cnt_next_s = div_cnt_r;
        if (clr) begin
            div_cnt_next_s = '0;
        end else if (en) begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_next_s = '0;
            end else begin
                div_cnt_next_s = div_cnt_r + DW'(1);
            end
        end else begin
            div_cnt_next_s = div_cnt_r;
        end
    end

    assign tick = (div_cnt_next_s == DIV_LAST);

    // Divider count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_next_s;
        end
    end

endmodule

// File: rtl/stream_serializer.sv
// Parallel-to-serial feeder with a one-word holding register for gapless back-to-back words.
module stream_serializer
    import pattern_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_DIV    = 1,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic              stream_out,
    output logic              stream_valid,
    output logic              bit_strobe,
    output logic              word_done
);

    localparam int unsigned BW = cnt_w(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 32'd1);

    st_e               state_r, state_next_s;
    logic [DATA_W-1:0] shifter_r, shifter_next_s;
    logic [DATA_W-1:0] hold_r, hold_next_s;
    logic              hold_full_r, hold_full_next_s;
    logic [BW-1:0]     bit_cnt_r, bit_cnt_next_s;
    logic              bit_end_r;
    logic              stream_out_r, stream_valid_r, bit_strobe_r, word_done_r;
    logic              accept_s, load_s, last_end_s, tick_s, div_en_s, div_clr_s;

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    assign in_ready   = ~hold_full_r;
    assign accept_s   = in_valid & ~hold_full_r;
    assign last_end_s = bit_end_r & (bit_cnt_r == BIT_LAST);

    // Next-state, shifter and hold-register decode; abort overrides accept and the last-bit transfer
    always_comb begin
        state_next_s     = state_r;
        shifter_next_s   = shifter_r;
        hold_next_s      = hold_r;
        hold_full_next_s = hold_full_r;
        bit_cnt_next_s   = bit_cnt_r;
        load_s           = 1'b0;
        if (abort) begin
            state_next_s     = IDLE;
            shifter_next_s   = '0;
            hold_next_s      = '0;
            hold_full_next_s = 1'b0;
            bit_cnt_next_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shifter_next_s = in_data;
                        bit_cnt_next_s = '0;
                        state_next_s   = SHIFT;
                        load_s         = 1'b1;
                    end else begin
                        state_next_s   = IDLE;
                    end
                end
                SHIFT: begin
                    // A word offered on the last bit with hold empty goes straight to the shifter
                    if (accept_s && !last_end_s) begin
                        hold_next_s      = in_data;
                        hold_full_next_s = 1'b1;
                    end else begin
                        hold_next_s      = hold_r;
                    end
                    if (last_end_s) begin
                        if (hold_full_r) begin
                            shifter_next_s   = hold_r;
                            hold_full_next_s = 1'b0;
                            bit_cnt_next_s   = '0;
                            load_s           = 1'b1;
                        end else if (accept_s) begin
                            shifter_next_s   = in_data;
                            bit_cnt_next_s   = '0;
                            load_s           = 1'b1;
                        end else begin
                            state_next_s     = IDLE;
                            shifter_next_s   = '0;
                            bit_cnt_next_s   = '0;
                        end
                    end else if (bit_end_r) begin
                        shifter_next_s = shift_word(shifter_r);
                        bit_cnt_next_s = bit_cnt_r + BW'(1);
                    end else begin
                        shifter_next_s = shifter_r;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    assign div_en_s  = (state_r == SHIFT);
    assign div_clr_s = abort | load_s | (state_next_s == IDLE);

    bit_rate_divider #(
        .BIT_DIV (BIT_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en_s),
        .clr  (div_clr_s),
        .tick (tick_s)
    );

    // State, datapath and registered outputs; strobe and done are decoded one cycle ahead
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            shifter_r      <= '0;
            hold_r         <= '0;
            hold_full_r    <= 1'b0;
            bit_cnt_r      <= '0;
            bit_end_r      <= 1'b0;
            stream_out_r   <= IDLE_LEVEL;
            stream_valid_r <= 1'b0;
            bit_strobe_r   <= 1'b0;
            word_done_r    <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            shifter_r      <= shifter_next_s;
            hold_r         <= hold_next_s;
            hold_full_r    <= hold_full_next_s;
            bit_cnt_r      <= bit_cnt_next_s;
            bit_end_r      <= tick_s & (state_next_s == SHIFT);
            stream_out_r   <= (state_next_s == SHIFT) ? head_bit(shifter_next_s) : IDLE_LEVEL;
            stream_valid_r <= (state_next_s == SHIFT);
            bit_strobe_r   <= (state_next_s == SHIFT) & (load_s | bit_end_r);
            word_done_r    <= (state_next_s == SHIFT) & tick_s & (bit_cnt_next_s == BIT_LAST);
        end
    end

    assign stream_out   = stream_out_r;
    assign stream_valid = stream_valid_r;
    assign bit_strobe   = bit_strobe_r;
    assign word_done    = word_done_r;

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench: instance a (MSB first, 1 cycle/bit) and instance b (LSB first, 3 cycles/bit).
module tb_stream_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, a_abort, b_abort;
    logic       a_ready, a_out, a_sv, a_strobe, a_done;
    logic       b_ready, b_out, b_sv, b_strobe, b_done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_serializer #(.DATA_W(8), .BIT_DIV(1), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .abort(a_abort), .stream_out(a_out), .stream_valid(a_sv), .bit_strobe(a_strobe),
        .word_done(a_done)
    );

    stream_serializer #(.DATA_W(8), .BIT_DIV(3), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .abort(b_abort), .stream_out(b_out), .stream_valid(b_sv), .bit_strobe(b_strobe),
        .word_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  w8;
        logic [15:0] w16;
        logic [7:0]  cur, got;
        logic [7:0]  q[$];
        int acc_cnt, last_acc, nbits, words;

        rst = 1'b1;
        a_data = 8'h00; a_valid = 1'b0; a_abort = 1'b0;
        b_data = 8'h00; b_valid = 1'b0; b_abort = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_a_ready", a_ready, 1);
        chk("rst_a_out", a_out, 0);
        chk("rst_a_valid", a_sv, 0);
        chk("rst_a_strobe", a_strobe, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_b_valid", b_sv, 0);
        #4 rst = 1'b1;
        tick();

        // Single word 8'hB4, MSB first
        w8 = 8'hB4;
        a_data = w8; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("single_bit", a_out, w8[7-i]);
            chk("single_valid", a_sv, 1);
            chk("single_strobe", a_strobe, 1);
            chk("single_done", a_done, (i == 7));
            chk("single_ready", a_ready, 1);
            tick();
        end
        chk("single_end_valid", a_sv, 0);
        chk("single_end_out", a_out, 0);
        chk("single_end_done", a_done, 0);
        tick();

        // Back-to-back 8'h68 then 8'hFF
        w16 = {8'h68, 8'hFF};
        a_data = 8'h68; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_bit", a_out, w16[15-i]);
            chk("b2b_valid", a_sv, 1);
            chk("b2b_done", a_done, (i == 7 || i == 15));
            chk("b2b_ready", a_ready, !(i >= 3 && i <= 7));
            if (i == 2) begin
                a_data = 8'hFF; a_valid = 1'b1;
            end else begin
                a_data = 8'h00; a_valid = 1'b0;
            end
            tick();
        end
        chk("b2b_end_valid", a_sv, 0);
        tick();

        // Asynchronous reset on bit 3 of a word
        a_data = 8'hB4; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick(); tick(); tick();
        chk("rstmid_bit3", a_out, 1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_valid", a_sv, 0);
        chk("rstmid_out", a_out, 0);
        chk("rstmid_ready", a_ready, 1);
        chk("rstmid_done", a_done, 0);
        chk("rstmid_strobe", a_strobe, 0);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rstmid_after_valid", a_sv, 0);
            chk("rstmid_after_done", a_done, 0);
        end

        // BIT_DIV=3, LSB first, 8'h01
        b_data = 8'h01; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            chk("div3_bit", b_out, (c < 3));
            chk("div3_valid", b_sv, 1);
            chk("div3_strobe", b_strobe, (c % 3 == 0));
            chk("div3_done", b_done, (c == 23));
            tick();
        end
        chk("div3_end_valid", b_sv, 0);
        chk("div3_end_out", b_out, 0);
        tick();

        // Abort at the start of the last bit with hold full
        w8 = 8'hF0;
        b_data = w8; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        for (int c = 0; c < 22; c++) begin
            chk("abort_bit", b_out, w8[c/3]);
            chk("abort_done_pre", b_done, 0);
            if (c == 3) chk("abort_hold_full", b_ready, 0);
            if (c == 1) begin
                b_data = 8'hAA; b_valid = 1'b1;
            end else begin
                b_valid = 1'b0;
            end
            if (c == 21) b_abort = 1'b1;
            tick();
        end
        b_abort = 1'b0;
        chk("abort_valid", b_sv, 0);
        chk("abort_out", b_out, 0);
        chk("abort_ready", b_ready, 1);
        chk("abort_done", b_done, 0);
        chk("abort_strobe", b_strobe, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_after_valid", b_sv, 0);
            chk("abort_after_done", b_done, 0);
        end

        // Backpressure: continuous in_valid with random data, scoreboard on the serial stream
        acc_cnt = 0; last_acc = 0; nbits = 0; words = 0; cur = 8'h00;
        for (int c = 0; c < 84; c++) begin
            a_valid = (c < 60);
            a_data  = 8'($urandom);
            if (a_valid && a_ready) begin
                q.push_back(a_data);
                acc_cnt++;
                if (acc_cnt >= 3) chk("bp_gap", c - last_acc, 8);
                last_acc = c;
            end
            tick();
            if (c < 60) chk("bp_valid", a_sv, 1);
            if (a_sv) begin
                cur = {cur[6:0], a_out};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    words++;
                    got = (q.size() > 0) ? q.pop_front() : 8'hxx;
                    chk("bp_word", cur, got);
                end
            end
        end
        a_valid = 1'b0;
        chk("bp_words", words, acc_cnt);
        chk("bp_left", q.size(), 0);
        chk("bp_partial", nbits, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
